data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter funnelling per-LSU read/write requests onto one data-memory channel, one transaction at a time.
// Consumer ready follows the memory ack by one edge and is held until the consumer drops valid; grants resume from IDLE.
module data_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic                                      mem_read_valid,
  output logic [ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                      mem_read_ready,
  input  logic [DATA_BITS-1:0]                      mem_read_data,
  output logic                                      mem_write_valid,
  output logic [ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_BITS-1:0]                      mem_write_data,
  input  logic                                      mem_write_ready
);

  localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t              state;
  logic [PTR_BITS-1:0] rr_ptr;
  logic [PTR_BITS-1:0] grant;
  logic [PTR_BITS-1:0] next_ptr;

  logic                pick_found;
  logic                pick_is_read;
  logic [PTR_BITS-1:0] pick_idx;

  // First requester at or after rr_ptr, wrapping; read beats write on the same port.
  always_comb begin
    int                  scan;
    logic [PTR_BITS-1:0] scan_idx;
    scan         = 0;
    scan_idx     = '0;
    pick_found   = 1'b0;
    pick_is_read = 1'b0;
    pick_idx     = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_CONSUMERS) scan = scan - NUM_CONSUMERS;
      scan_idx = PTR_BITS'(scan);
      if (!pick_found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        pick_found   = 1'b1;
        pick_is_read = consumer_read_valid[scan_idx];
        pick_idx     = scan_idx;
      end
    end
  end

  assign next_ptr = (grant == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant + PTR_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            if (pick_is_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick_idx];
              state            <= READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick_idx];
              mem_write_data    <= consumer_write_data[pick_idx];
              state             <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            consumer_read_data[grant]  <= mem_read_data;
            consumer_read_ready[grant] <= 1'b1;
            state                      <= READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            state                       <= WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[grant]) begin
            consumer_read_ready[grant] <= 1'b0;
            rr_ptr                     <= next_ptr;
            state                      <= IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[grant]) begin
            consumer_write_ready[grant] <= 1'b0;
            rr_ptr                      <= next_ptr;
            state                       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized bench for data_mem_arbiter; the bench plays both the LSUs and the data memory.
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]         consumer_read_valid;
  logic [N-1:0][AW-1:0] consumer_read_address;
  logic [N-1:0]         consumer_read_ready;
  logic [N-1:0][DW-1:0] consumer_read_data;
  logic [N-1:0]         consumer_write_valid;
  logic [N-1:0][AW-1:0] consumer_write_address;
  logic [N-1:0][DW-1:0] consumer_write_data;
  logic [N-1:0]         consumer_write_ready;
  logic                 mem_read_valid;
  logic [AW-1:0]        mem_read_address;
  logic                 mem_read_ready;
  logic [DW-1:0]        mem_read_data;
  logic                 mem_write_valid;
  logic [AW-1:0]        mem_write_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_ready;

  data_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: pending requests per consumer, round-robin pointer, memory contents.
  int            rr;
  bit            pend_r [N];
  bit            pend_w [N];
  logic [AW-1:0] raddr  [N];
  logic [AW-1:0] waddr  [N];
  logic [DW-1:0] wdata  [N];
  logic [DW-1:0] mem    [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      consumer_read_valid[i]    = pend_r[i];
      consumer_read_address[i]  = raddr[i];
      consumer_write_valid[i]   = pend_w[i];
      consumer_write_address[i] = waddr[i];
      consumer_write_data[i]    = wdata[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_rdy"},  64'(consumer_read_ready), 64'(0));
    chk({tag, "_wr_rdy"},  64'(consumer_write_ready), 64'(0));
    chk({tag, "_rd_data"}, 64'(consumer_read_data), 64'(0));
    chk({tag, "_mem_out"}, 64'({mem_read_valid, mem_read_address, mem_write_valid,
                                mem_write_address, mem_write_data}), 64'(0));
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      pend_r[i] = 1'b0;
      pend_w[i] = 1'b0;
    end
    drive();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rr = 0;
  endtask

  function automatic bit any_pending();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a |= pend_r[i] | pend_w[i];
    return a;
  endfunction

  // Serves the next transaction the model predicts: waits for the memory request, acks it after
  // `delay` cycles, holds the consumer valid `hold` extra cycles, then drops it.
  task automatic serve(input int delay, input int hold);
    int   g;
    bit   is_rd;
    bit   seen;
    logic [1:0] vpair;
    g = -1;
    is_rd = 1'b0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (rr + i) % N;
      if (g < 0 && (pend_r[c] || pend_w[c])) begin
        g = c;
        is_rd = pend_r[c];
      end
    end
    if (g < 0) return;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = mem_read_valid || mem_write_valid;
    end
    chk("grant_seen", 64'(seen), 64'(1));
    if (!seen) begin
      if (is_rd) pend_r[g] = 1'b0; else pend_w[g] = 1'b0;
      drive();
      return;
    end
    vpair = is_rd ? 2'b10 : 2'b01;
    chk("mem_valid_kind", 64'({mem_read_valid, mem_write_valid}), 64'(vpair));
    if (is_rd) chk("mem_read_address", 64'(mem_read_address), 64'(raddr[g]));
    else begin
      chk("mem_write_address", 64'(mem_write_address), 64'(waddr[g]));
      chk("mem_write_data", 64'(mem_write_data), 64'(wdata[g]));
    end
    repeat (delay) tick();
    if (delay > 0) begin
      chk("wait_valid_held", 64'({mem_read_valid, mem_write_valid}), 64'(vpair));
      chk("wait_no_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'(0));
      if (is_rd) chk("wait_rd_addr", 64'(mem_read_address), 64'(raddr[g]));
      else chk("wait_wr_addr_data", 64'({mem_write_address, mem_write_data}),
               64'({waddr[g], wdata[g]}));
    end
    if (is_rd) begin
      mem_read_data  = mem[mem_read_address];
      mem_read_ready = 1'b1;
    end else begin
      mem[waddr[g]]   = wdata[g];
      mem_write_ready = 1'b1;
    end
    tick();
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'($urandom);
    chk("mem_valid_clear", 64'({mem_read_valid, mem_write_valid}), 64'(0));
    if (is_rd) begin
      chk("read_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'(1) << (g + N));
      chk("read_data", 64'(consumer_read_data[g]), 64'(mem[raddr[g]]));
    end else begin
      chk("write_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'(1) << g);
    end
    repeat (hold) begin
      tick();
      chk("ready_held", 64'({consumer_read_ready, consumer_write_ready}),
          is_rd ? (64'(1) << (g + N)) : (64'(1) << g));
    end
    if (is_rd) pend_r[g] = 1'b0; else pend_w[g] = 1'b0;
    drive();
    tick();
    chk("ready_drop", 64'({consumer_read_ready, consumer_write_ready}), 64'(0));
    if (is_rd) chk("read_data_hold", 64'(consumer_read_data[g]), 64'(mem[raddr[g]]));
    rr = (g + 1) % N;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      raddr[i] = '0;
      waddr[i] = '0;
      wdata[i] = '0;
    end
    mem_read_data = '0;
    do_reset();
    check_all_zero("reset");

    // Stray memory ack while idle with no requests.
    mem_read_ready = 1'b1;
    mem_read_data  = 8'hC3;
    tick();
    mem_read_ready = 1'b0;
    check_all_zero("idle_ack");
    tick();
    check_all_zero("idle_ack_later");

    // Single read from consumer 2.
    mem[8'h10] = 8'h5A;
    raddr[2]   = 8'h10;
    pend_r[2]  = 1'b1;
    drive();
    serve(2, 1);

    // All four read after reset; consumer 0 re-requests and wins after 3.
    do_reset();
    for (int i = 0; i < N; i++) begin
      raddr[i]  = 8'(8'h40 + i);
      pend_r[i] = 1'b1;
    end
    drive();
    serve(0, 0);
    raddr[0]  = 8'h50;
    pend_r[0] = 1'b1;
    drive();
    for (int k = 0; k < N; k++) serve(1, 0);

    // Consumer 1 read and write together: read first, then the write.
    raddr[1]  = 8'h21;
    waddr[1]  = 8'h20;
    wdata[1]  = 8'h33;
    pend_r[1] = 1'b1;
    pend_w[1] = 1'b1;
    drive();
    serve(1, 1);
    serve(1, 1);
    raddr[2]  = 8'h20;
    pend_r[2] = 1'b1;
    drive();
    serve(0, 0);

    // Slow write ack for consumer 3.
    waddr[3]  = 8'h7F;
    wdata[3]  = 8'hAA;
    pend_w[3] = 1'b1;
    drive();
    serve(5, 2);

    // Reset while a read is waiting on memory.
    raddr[0]  = 8'h44;
    pend_r[0] = 1'b1;
    drive();
    tick();
    chk("rst_mid_grant", 64'(mem_read_valid), 64'(1));
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    pend_r[0] = 1'b0;
    drive();
    reset = 1'b0;
    rr = 0;
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    check_all_zero("late_ack");

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        pend_r[i] = ($urandom_range(0, 1) == 1);
        pend_w[i] = ($urandom_range(0, 2) == 0);
        raddr[i]  = 8'($urandom);
        waddr[i]  = 8'($urandom);
        wdata[i]  = 8'($urandom);
      end
      drive();
      for (int s = 0; s < 2 * N && any_pending(); s++)
        serve($urandom_range(0, 4), $urandom_range(0, 2));
      tick();
      chk("round_idle", 64'({mem_read_valid, mem_write_valid}), 64'(0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
